// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART receive path.
//   rx_entry_t : one buffered frame, {framing error, data byte}
//   rx_state_t : capture FSM states of rx_buffer
//   mask_data  : clears data bits above the configured character width
// ----------------------------------------------------------------------------
package uart_pkg;

    localparam logic [3:0] MIN_DATA_SIZE = 4'd5;
    localparam logic [3:0] MAX_DATA_SIZE = 4'd8;

    typedef struct packed {
        logic       fe;
        logic [7:0] data;
    } rx_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        ACK,
        WAIT_CLR
    } rx_state_t;

    // Unsupported widths fall back to a full byte so nothing is silently lost.
    function automatic logic [7:0] mask_data(input logic [7:0] data,
                                             input logic [3:0] size);
        logic [3:0] eff_size;
        logic [7:0] mask;
        eff_size = (size >= MIN_DATA_SIZE && size <= MAX_DATA_SIZE) ? size : MAX_DATA_SIZE;
        mask     = 8'hFF >> (MAX_DATA_SIZE - eff_size);
        return data & mask;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with occupancy counter and a combinational head view.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   push_i, wdata_i: write request and data (ignored when full without pop)
//   pop_i          : consume head entry (ignored when empty)
//   rdata_o        : head entry; shows the last popped entry while empty
//   count_o        : occupancy 0..DEPTH
//   full_o, empty_o: occupancy flags
// ----------------------------------------------------------------------------
module sync_fifo #(
    parameter  int WIDTH = 9,
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [PTR_W:0]   count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] prev_rd_ptr;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == FULL_COUNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    // A pop while full frees the slot the push lands in, so both may proceed.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // While empty, the slot behind the read pointer is the entry popped last;
    // no write can reach it before the FIFO has been refilled.
    assign prev_rd_ptr = rd_ptr_q - 1'b1;
    assign rdata_o     = empty_o ? mem_q[prev_rd_ptr] : mem_q[rd_ptr_q];

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: the storage is reset too, because the head view must read zero
    // straight out of reset; at DEPTH <= 64 this is a plain register array.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) mem_q[wr_ptr_q] <= wdata_i;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/rx_buffer.sv
// ----------------------------------------------------------------------------
// rx_buffer
// Buffers frames from the UART receiver (rcv_block) for the APB register slave.
// A three-state capture FSM writes each pending byte once, acknowledges it
// with a one-cycle data_read pulse and waits for data_ready to drop.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   rx_data, data_ready,
//   framing_error, overrun_error  : receiver side
//   data_size                     : character width 5..8 (others mean 8)
//   data_read                     : registered one-cycle acknowledge
//   pop, rdata, empty, full, count: APB-side FIFO view, rdata = {fe, data}
//   ovr_sticky, fe_sticky, clr_err: sticky error status and its clear
// Optional (macro RX_BUFFER_THRESH_IRQ_EN):
//   thresh : occupancy watermark, 0 disables the watermark term
//   irq    : registered interrupt (watermark or any sticky error)
// ----------------------------------------------------------------------------
module rx_buffer
    import uart_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [7:0]     rx_data,
    input  logic           data_ready,
    input  logic           framing_error,
    input  logic           overrun_error,
    input  logic [3:0]     data_size,
    output logic           data_read,
    input  logic           pop,
    output logic [8:0]     rdata,
    output logic           empty,
    output logic           full,
    output logic [PTR_W:0] count,
    output logic           ovr_sticky,
    output logic           fe_sticky,
`ifdef RX_BUFFER_THRESH_IRQ_EN
    input  logic [PTR_W:0] thresh,
    output logic           irq,
`endif
    input  logic           clr_err
);

    rx_state_t state_q, state_d;
    logic      data_read_q, data_read_d;
    logic      ovr_q, ovr_d;
    logic      fe_q, fe_d;
    logic      push;
    logic      ovr_evt;
    logic      fe_evt;
    rx_entry_t entry;

    assign entry = '{fe: framing_error, data: mask_data(rx_data, data_size)};

    sync_fifo #(
        .WIDTH (9),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i (entry),
        .pop_i   (pop),
        .rdata_o (rdata),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        ovr_evt = overrun_error;
        case (state_q)
            IDLE: begin
                if (data_ready) begin
                    if (!full || pop) begin
                        push    = 1'b1;
                        state_d = ACK;
                    end else begin
                        // Byte stays in rcv_block; flag that we could not take it.
                        ovr_evt = 1'b1;
                    end
                end
            end
            ACK:      state_d = WAIT_CLR;
            // Holding here until data_ready drops prevents a double capture.
            WAIT_CLR: if (!data_ready) state_d = IDLE;
            default:  state_d = IDLE;
        endcase

        data_read_d = (state_d == ACK);
        fe_evt      = push && framing_error;

        // A set event in the same cycle beats the clear.
        ovr_d = ovr_evt ? 1'b1 : (clr_err ? 1'b0 : ovr_q);
        fe_d  = fe_evt  ? 1'b1 : (clr_err ? 1'b0 : fe_q);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            data_read_q <= 1'b0;
            ovr_q       <= 1'b0;
            fe_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_read_q <= data_read_d;
            ovr_q       <= ovr_d;
            fe_q        <= fe_d;
        end
    end

    assign data_read  = data_read_q;
    assign ovr_sticky = ovr_q;
    assign fe_sticky  = fe_q;

`ifdef RX_BUFFER_THRESH_IRQ_EN
    logic irq_q, irq_d;

    assign irq_d = ((count >= thresh) && (thresh != '0)) || ovr_q || fe_q;

    always_ff @(posedge clk) begin
        if (rst) irq_q <= 1'b0;
        else     irq_q <= irq_d;
    end

    assign irq = irq_q;
`endif

endmodule
